// File: rtl/lut_load_ctrl.sv
// Serial load sequencer for the shift-register LUT: takes table words over valid/ready
// and shifts them MSB-first on sd/sclk/scs_n. Optional checksum output: LUT_LOAD_CHECKSUM_EN.
module lut_load_ctrl #(
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH = 3,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [OUT_WIDTH-1:0] wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic                 sclk,
    output logic                 sd,
    output logic                 scs_n,
    output logic                 busy,
    output logic                 done,
    output logic                 table_valid
`ifdef LUT_LOAD_CHECKSUM_EN
    ,
    output logic [OUT_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned ENTRIES = 1 << IN_WIDTH;
    localparam int unsigned BCW     = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int unsigned DCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   entry_cnt_q, entry_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0]        div_cnt_q, div_cnt_d;
    logic [OUT_WIDTH-1:0]  word_q, word_d;
    logic [OUT_WIDTH-1:0]  word_shift;
    logic                  sclk_q, sclk_d;
    logic                  sd_q, sd_d;
    logic                  scs_n_q, scs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tv_q, tv_d;
`ifdef LUT_LOAD_CHECKSUM_EN
    logic [OUT_WIDTH-1:0]  cks_q, cks_d;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            entry_cnt_q <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            word_q      <= '0;
            sclk_q      <= 1'b0;
            sd_q        <= 1'b0;
            scs_n_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tv_q        <= 1'b0;
`ifdef LUT_LOAD_CHECKSUM_EN
            cks_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            entry_cnt_q <= entry_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            word_q      <= word_d;
            sclk_q      <= sclk_d;
            sd_q        <= sd_d;
            scs_n_q     <= scs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tv_q        <= tv_d;
`ifdef LUT_LOAD_CHECKSUM_EN
            cks_q       <= cks_d;
`endif
        end
    end

    assign word_shift = word_q << 1;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        entry_cnt_d = entry_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        word_d      = word_q;
        sclk_d      = sclk_q;
        sd_d        = sd_q;
        scs_n_d     = scs_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tv_d        = tv_q;
`ifdef LUT_LOAD_CHECKSUM_EN
        cks_d       = cks_q;
`endif

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            scs_n_d = 1'b1;
            sclk_d  = 1'b0;
            sd_d    = 1'b0;
            busy_d  = 1'b0;
            tv_d    = 1'b0;
`ifdef LUT_LOAD_CHECKSUM_EN
            cks_d   = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        tv_d        = 1'b0;
                        busy_d      = 1'b1;
                        entry_cnt_d = IN_WIDTH'(ENTRIES - 1);
`ifdef LUT_LOAD_CHECKSUM_EN
                        cks_d       = '0;
`endif
                    end else if (abort) begin
                        tv_d = 1'b0;
                    end
                end
                S_FETCH: begin
                    sclk_d = 1'b0;
                    if (wr_valid) begin
                        word_d    = wr_data;
                        bit_cnt_d = BCW'(OUT_WIDTH - 1);
                        div_cnt_d = '0;
                        scs_n_d   = 1'b0;
                        sd_d      = wr_data[OUT_WIDTH-1];
                        state_d   = S_SHIFT;
`ifdef LUT_LOAD_CHECKSUM_EN
                        cks_d     = cks_q ^ wr_data;
`endif
                    end
                end
                S_SHIFT: begin
                    // Each sclk phase lasts CLK_DIV cycles; data moves only as sclk falls.
                    if (div_cnt_q == DCW'(CLK_DIV - 1)) begin
                        div_cnt_d = '0;
                        if (!sclk_q) begin
                            sclk_d = 1'b1;
                        end else begin
                            sclk_d = 1'b0;
                            if (bit_cnt_q != '0) begin
                                bit_cnt_d = bit_cnt_q - BCW'(1);
                                word_d    = word_shift;
                                sd_d      = word_shift[OUT_WIDTH-1];
                            end else if (entry_cnt_q != '0) begin
                                entry_cnt_d = entry_cnt_q - IN_WIDTH'(1);
                                state_d     = S_FETCH;
                            end else begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                scs_n_d = 1'b1;
                                sd_d    = 1'b0;
                                busy_d  = 1'b0;
                                tv_d    = 1'b1;
                            end
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DCW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign wr_ready    = (state_q == S_FETCH);
    assign sclk        = sclk_q;
    assign sd          = sd_q;
    assign scs_n       = scs_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign table_valid = tv_q;
`ifdef LUT_LOAD_CHECKSUM_EN
    assign checksum    = cks_q;
`endif

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Directed bench for lut_load_ctrl: shift-register LUT model on the serial pins,
// done timing, backpressure, abort, reset mid-load and a 1-bit/CLK_DIV=1 instance.
module tb_lut_load_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, wr_valid;
    logic [2:0] wr_data;
    logic       wr_ready, sclk, sd, scs_n, busy, done, table_valid;

    logic       start1, wr_valid1;
    logic [0:0] wr_data1;
    logic       wr_ready1, sclk1, sd1, scs_n1, busy1, done1, table_valid1;
`ifdef LUT_LOAD_CHECKSUM_EN
    logic [2:0] checksum;
    logic [0:0] checksum1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] sr  = '0;
    logic [15:0] sr1 = '0;
    int edges = 0, tot = 0, edges1 = 0;

    always #5 clk = ~clk;

    lut_load_ctrl #(.IN_WIDTH(4), .OUT_WIDTH(3), .CLK_DIV(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .sclk(sclk), .sd(sd), .scs_n(scs_n), .busy(busy), .done(done),
        .table_valid(table_valid)
`ifdef LUT_LOAD_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    lut_load_ctrl #(.IN_WIDTH(4), .OUT_WIDTH(1), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .wr_data(wr_data1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
        .sclk(sclk1), .sd(sd1), .scs_n(scs_n1), .busy(busy1), .done(done1),
        .table_valid(table_valid1)
`ifdef LUT_LOAD_CHECKSUM_EN
        , .checksum(checksum1)
`endif
    );

    // Behavioural LUT shift registers, clocked by sclk while scs_n is low
    always @(posedge sclk) begin
        tot = tot + 1;
        if (!scs_n) begin
            sr <= {sr[46:0], sd};
            edges = edges + 1;
        end
    end

    always @(posedge sclk1) begin
        if (!scs_n1) begin
            sr1 <= {sr1[14:0], sd1};
            edges1 = edges1 + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] word_of(input int mode, input int idx);
        if (mode == 1) return (idx == 15) ? 3'd2 : 3'd5;
        return 3'(7 - (idx % 8));
    endfunction

    // Runs one load; returns at the done cycle, one cycle after an abort/reset, or on timeout
    task automatic run_load(input int mode, input int gap_word, input int gap_len,
                            input int abort_at, input int rst_at, input bit spam,
                            output int done_cyc);
        int  idx      = 0;
        int  gap_left = gap_len;
        int  cyc;
        bit  ev       = 1'b0;
        done_cyc = -1;
        @(negedge clk);
        start    = 1'b1;
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 400 && !ev) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            wr_data  = word_of(mode, idx);
            wr_valid = 1'b1;
            if (wr_ready && idx == gap_word && gap_left > 0) begin
                wr_valid = 1'b0;
                gap_left--;
                check_eq("gap_sclk_scs_n", 64'({sclk, scs_n}), 64'd0);
            end
            if (spam && (cyc == 20 || cyc == 150)) start = 1'b1;
            if (cyc == abort_at) begin
                check_eq("pre_abort_scs_n", 64'(scs_n), 64'd0);
                abort = 1'b1;
                ev    = 1'b1;
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                ev  = 1'b1;
            end
            if (wr_ready && wr_valid) idx++;
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            cyc++;
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_table(input string pfx);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("%s_entry%0d", pfx, i), 64'(sr[3*i +: 3]), 64'(i % 8));
    endtask

    task automatic check_done_tail(input string pfx);
        check_eq({pfx, "_done_pins"}, 64'({table_valid, busy, scs_n, sclk}), 64'b1010);
        @(posedge clk);
        #1;
        check_eq({pfx, "_after_done"}, 64'({done, table_valid, busy}), 64'b010);
    endtask

    initial begin
        int dc, e0, t0, seen_done;
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0;
        start1 = 1'b0; wr_valid1 = 1'b0; wr_data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        // {sclk, sd, scs_n, wr_ready, busy, done, table_valid}
        check_eq("reset_pins", 64'({sclk, sd, scs_n, wr_ready, busy, done, table_valid}), 64'b0010000);
        check_eq("reset_pins_dut1", 64'({sclk1, sd1, scs_n1, wr_ready1, busy1, done1, table_valid1}),
                 64'b0010000);
        rst = 1'b0;

        // Full load, no stalls
        e0 = edges; t0 = tot;
        run_load(0, -1, 0, -1, -1, 1'b0, dc);
        check_eq("t1_done_cycle", 64'(dc), 64'd209);
        check_eq("t1_gated_edges", 64'(edges - e0), 64'd48);
        check_eq("t1_total_edges", 64'(tot - t0), 64'd48);
        check_table("t1");
        check_done_tail("t1");

        // Backpressure before word 8
        e0 = edges; t0 = tot;
        run_load(0, 8, 5, -1, -1, 1'b0, dc);
        check_eq("t2_done_cycle", 64'(dc), 64'd214);
        check_eq("t2_gated_edges", 64'(edges - e0), 64'd48);
        check_eq("t2_total_edges", 64'(tot - t0), 64'd48);
        check_table("t2");
        check_done_tail("t2");

        // Abort while word 3 is shifting
        run_load(0, -1, 0, 45, -1, 1'b0, dc);
        check_eq("t3_abort_pins", 64'({scs_n, sclk, sd, busy, done, table_valid}), 64'b100000);
        seen_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check_eq("t3_no_done", 64'(seen_done), 64'd0);
        check_eq("t3_tv_idle", 64'({table_valid, busy}), 64'b00);
        e0 = edges;
        run_load(0, -1, 0, -1, -1, 1'b0, dc);
        check_eq("t3_reload_done_cycle", 64'(dc), 64'd209);
        check_eq("t3_reload_edges", 64'(edges - e0), 64'd48);
        check_table("t3");
        check_done_tail("t3");

        // Reset mid-load, then a load with stray start pulses
        run_load(0, -1, 0, -1, 100, 1'b0, dc);
        check_eq("t4_reset_pins", 64'({sclk, sd, scs_n, wr_ready, busy, done, table_valid}), 64'b0010000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_tv_after_reset", 64'(table_valid), 64'd0);
        run_load(0, -1, 0, -1, -1, 1'b1, dc);
        check_eq("t4_spam_done_cycle", 64'(dc), 64'd209);
        check_table("t4");
        check_done_tail("t4");

        // OUT_WIDTH=1, CLK_DIV=1 instance
        begin
            int idx1 = 0, hi = 0, cyc = 1, d1 = -1;
            e0 = edges1;
            @(negedge clk);
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            while (cyc < 200) begin
                if (done1) begin
                    d1 = cyc;
                    break;
                end
                wr_data1  = 1'((15 - idx1) % 2);
                wr_valid1 = 1'b1;
                if (busy1 && !wr_ready1 && sclk1) hi++;
                if (wr_ready1) idx1++;
                @(posedge clk);
                #1;
                cyc++;
            end
            wr_valid1 = 1'b0;
            check_eq("t5_done_cycle", 64'(d1), 64'd49);
            check_eq("t5_edges", 64'(edges1 - e0), 64'd16);
            check_eq("t5_high_cycles", 64'(hi), 64'd16);
            for (int i = 0; i < 16; i++)
                check_eq($sformatf("t5_entry%0d", i), 64'(sr1[i]), 64'(i % 2));
            check_eq("t5_table_valid", 64'(table_valid1), 64'd1);
        end

`ifdef LUT_LOAD_CHECKSUM_EN
        run_load(1, -1, 0, -1, -1, 1'b0, dc);
        check_eq("t6_done_cycle", 64'(dc), 64'd209);
        check_eq("t6_checksum", 64'(checksum), 64'd7);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("t6_checksum_cleared", 64'(checksum), 64'd0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq("t6_after_abort", 64'({checksum, busy}), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_load_ctrl.md
Name: lut_load_ctrl

Overview:
Load sequencer for the serial-load LUT: accepts 2**IN_WIDTH table entries over a valid/ready word interface and shifts them bit-serially into the LUT's shift register. It drives the LUT's d, clk and cs_n pins (sd, sclk, scs_n) with a programmable serial clock rate. It flags when the table is coherent so downstream logic only uses lookups after a complete load. It sits between the host-side config source and the serial_load_lut pins.

Parameters:
IN_WIDTH, 4, LUT select width; ENTRIES = 2**IN_WIDTH
OUT_WIDTH, 3, LUT entry width; bits per word
CLK_DIV, 2, system cycles per sclk half-period (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin a full table load (sampled in IDLE only)
abort  in  1  cancel load in progress
wr_data  in  OUT_WIDTH  table entry word
wr_valid  in  1  wr_data valid
wr_ready  out  1  controller accepts word this cycle
sclk  out  1  serial clock to LUT shift register
sd  out  1  serial data to LUT, MSB-first
scs_n  out  1  LUT shift enable, active-low
busy  out  1  load in progress
done  out  1  one-cycle pulse on successful load completion
table_valid  out  1  LUT holds a complete, uncorrupted table

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; sclk=0, sd=0, scs_n=1, wr_ready=0, busy=0, done=0, table_valid=0; counters cleared.
- Word order: words accepted in descending entry index (ENTRIES-1 first, 0 last), each shifted MSB-first. After a full load, LUT entry i equals the i-th-from-last accepted word.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 -> FETCH next cycle; table_valid<=0, busy<=1, entry_cnt<=ENTRIES-1. start while busy is ignored.
- FETCH: wr_ready=1 (combinational from state). On wr_valid&wr_ready: latch word, bit_cnt<=OUT_WIDTH-1, div_cnt<=0, go SHIFT. scs_n<=0 on that edge. sd<=word MSB on that edge. No handshake: hold state. sclk=0. scs_n keeps its value (low between words).
- SHIFT: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. sd is stable across each rising edge of sclk.
- At the end of the high phase with bit_cnt>0: bit_cnt--, sd<=next bit, sclk<=0.
- At the end of the high phase with bit_cnt==0 and entry_cnt>0: entry_cnt--, sclk<=0, go FETCH.
- At the end of the high phase with bit_cnt==0 and entry_cnt==0: go DONE.
- DONE (one cycle): done=1, scs_n=1, sclk=0, busy=0, table_valid=1; next state IDLE.
- Timing with wr_valid held high: each word costs 1 FETCH cycle + 2*CLK_DIV*OUT_WIDTH SHIFT cycles. With defaults and start at cycle 0, the last handshake is at cycle 196 and done pulses at cycle 209.
- Abort (any non-IDLE state): next cycle IDLE, scs_n=1, sclk=0, sd=0, busy=0, table_valid=0, no done pulse. Abort takes priority over a simultaneous handshake. Abort in IDLE has no effect, except it clears table_valid.
- rst mid-load: same outputs as reset. table_valid stays 0 until a fresh complete load.
- Exactly ENTRIES*OUT_WIDTH sclk rising edges occur with scs_n=0 per successful load. No sclk edges occur outside SHIFT.

Optional Feature:
LUT_LOAD_CHECKSUM_EN defined:
- Adds output port checksum [OUT_WIDTH-1:0].
- Cleared when start is accepted; XOR-accumulates every accepted word.
- Value is meaningful while table_valid=1. Reset value 0. Abort clears it.
LUT_LOAD_CHECKSUM_EN undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Full load, defaults, wr_valid always high, words 7,6,5,4,3,2,1,0,7,...,0 (entry i = i mod 8) -> done at cycle 209; a behavioural 48-bit shift-register model clocked by sclk/scs_n gives LUT sel=i output i mod 8 for all 16 i; table_valid=1.
- Backpressure: wr_valid low 5 cycles before word 8 -> scs_n stays 0, sclk stays 0 during the gap, no extra edges, done delayed to cycle 214, table contents unchanged from the first test.
- Abort during SHIFT of word 3 -> next cycle scs_n=1, busy=0, no done, table_valid=0; a subsequent full load succeeds normally.
- rst asserted at cycle 100 of a load -> all outputs at reset values next cycle; start pulses during busy in a separate run are ignored (done still at cycle 209).
- CLK_DIV=1, single-bit entries (OUT_WIDTH=1) -> sclk toggles every cycle, each word takes 3 cycles, 16 sclk edges total.
- With LUT_LOAD_CHECKSUM_EN: fifteen words 3'b101 and one 3'b010 -> checksum=3'b111 when done; after a new start, checksum=0.
